writeback_regfile: RTL

//   Write-back stage of the sequential Y86-64 core; sits directly downstream of Memory.

---
 rtl/writeback_regfile.sv | 70 +++++++
 1 files changed

// File: rtl/writeback_regfile.sv
// writeback_regfile: Y86-64 write-back stage with 15x64 register file, sticky status and retire counter.
// Optional WB_BYPASS_EN forwards this cycle's enabled write data to the read ports.
module writeback_regfile #(
    parameter int DATA_W = 64,
    parameter int CNT_W = 32,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [3:0]        icode,
    input  logic              Cnd,
    input  logic [3:0]        dstE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              InstrValid,
    input  logic              InstrMemError,
    input  logic              DataMemError,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [2:0]        Stat,
    output logic [CNT_W-1:0]  RetireCnt
);
    typedef enum logic [2:0] {AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4} stat_t;
    stat_t             stat;
    logic [DATA_W-1:0] regs [0:14];
    logic [CNT_W-1:0]  cnt;
    logic              fault, en, we_e, we_m;

    always_comb begin
        fault = DataMemError | InstrMemError;
        en    = (stat == AOK) & ~fault & InstrValid & (icode != 4'h0);
        // a failed cmovXX (icode 2, Cnd 0) completes but writes nothing
        we_e  = en & (dstE != 4'hF) & ~((icode == 4'h2) & ~Cnd);
        we_m  = en & (dstM != 4'hF);
    end

    // port M is written last so valM wins when dstE == dstM
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stat <= AOK;
            cnt  <= '0;
            for (int i = 0; i < 15; i++) regs[i] <= (i == 4) ? RSP_INIT : '0;
        end else begin
            if (stat == AOK) stat <= fault ? ADR : !InstrValid ? INS : (icode == 4'h0) ? HLT : AOK;
            if (en) cnt <= cnt + CNT_W'(1);
            if (we_e) regs[dstE] <= valE;
            if (we_m) regs[dstM] <= valM;
        end
    end

    function automatic logic [DATA_W-1:0] rd(input logic [3:0] s);
        if (s == 4'hF) return '0;
`ifdef WB_BYPASS_EN
        if (we_m && dstM == s) return valM;
        if (we_e && dstE == s) return valE;
`endif
        return regs[s];
    endfunction

    always_comb begin
        valA = rd(srcA);
        valB = rd(srcB);
    end

    assign Stat      = stat;
    assign RetireCnt = cnt;
endmodule
